// File: rtl/dso_pkg.sv
// Shared constants for the DSO capture path: ADC width, decimation modes and
// the default width of the decimation ratio.
package dso_pkg;

    localparam int ADC_W          = 8;
    localparam int RATE_W_DEFAULT = 24;

    typedef enum logic {
        DECI_MODE_SAMPLE = 1'b0,
        DECI_MODE_PEAK   = 1'b1
    } deci_mode_e;

endpackage

// File: rtl/dso_peak_acc.sv
// Running unsigned max/min over a decimation window. Outputs already fold in
// the current sample so the closing sample takes part in the result.
module dso_peak_acc
    import dso_pkg::*;
(
    input  logic             ad_clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             update,
    input  logic [ADC_W-1:0] din,
    output logic [ADC_W-1:0] max_o,
    output logic [ADC_W-1:0] min_o
);

    logic [ADC_W-1:0] acc_max;
    logic [ADC_W-1:0] acc_min;

    function automatic logic [ADC_W-1:0] umax(input logic [ADC_W-1:0] a,
                                              input logic [ADC_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [ADC_W-1:0] umin(input logic [ADC_W-1:0] a,
                                              input logic [ADC_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // First sample of a window replaces the accumulators outright
    assign max_o = load ? din : umax(acc_max, din);
    assign min_o = load ? din : umin(acc_min, din);

    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            acc_max <= '0;
            acc_min <= '1;
        end else if (clr) begin
            acc_max <= '0;
            acc_min <= '1;
        end else if (load || update) begin
            acc_max <= max_o;
            acc_min <= min_o;
        end
    end

endmodule

// File: rtl/dso_decimator.sv
// Decimates the ADC sample stream by N, either keeping the last sample of each
// window or alternating window max/min so short glitches stay visible.
module dso_decimator
    import dso_pkg::*;
#(
    parameter int RATE_W = RATE_W_DEFAULT
) (
    input  logic              ad_clk,
    input  logic              rst,
    input  logic [ADC_W-1:0]  ad_data_in,
    input  logic [RATE_W-1:0] deci_rate,
    input  logic              deci_mode,
    output logic              deci_valid,
    output logic [ADC_W-1:0]  deci_data,
    output logic              cfg_restart
);

    logic [RATE_W-1:0] rate_q;
    logic              mode_q;
    logic [RATE_W-1:0] win_cnt;
    logic              phase;
    logic              cfg_change_p0;
    logic              win_first_p0;
    logic              win_close_p0;
    logic [ADC_W-1:0]  peak_max_p0;
    logic [ADC_W-1:0]  peak_min_p0;
    logic [ADC_W-1:0]  peak_sel_p0;

    // Last count of a window, Neff-1; a ratio of 0 behaves as 1
    function automatic logic [RATE_W-1:0] last_cnt(input logic [RATE_W-1:0] rate);
        return (rate == '0) ? '0 : rate - RATE_W'(1);
    endfunction

    // rate_q/mode_q govern the running window; a port value that differs from
    // them is a config change, so the partial window is dropped the same cycle.
    assign cfg_change_p0 = (deci_rate != rate_q) || (deci_mode != mode_q);
    assign win_first_p0  = (win_cnt == '0);
    assign win_close_p0  = (win_cnt == last_cnt(rate_q));
    assign peak_sel_p0   = phase ? peak_min_p0 : peak_max_p0;

    dso_peak_acc u_peak_acc (
        .ad_clk (ad_clk),
        .rst    (rst),
        .clr    (cfg_change_p0),
        .load   (!cfg_change_p0 && win_first_p0),
        .update (!cfg_change_p0 && !win_first_p0),
        .din    (ad_data_in),
        .max_o  (peak_max_p0),
        .min_o  (peak_min_p0)
    );

    // ---- p0 -> registered outputs ----
    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            rate_q      <= deci_rate;
            mode_q      <= deci_mode;
            win_cnt     <= '0;
            phase       <= 1'b0;
            deci_valid  <= 1'b0;
            deci_data   <= '0;
            cfg_restart <= 1'b0;
        end else begin
            rate_q      <= deci_rate;
            mode_q      <= deci_mode;
            cfg_restart <= cfg_change_p0;
            deci_valid  <= 1'b0;
            if (cfg_change_p0) begin
                win_cnt <= '0;
                phase   <= 1'b0;
            end else if (win_close_p0) begin
                win_cnt    <= '0;
                deci_valid <= 1'b1;
                if (mode_q == DECI_MODE_PEAK) begin
                    deci_data <= peak_sel_p0;
                    phase     <= ~phase;
                end else begin
                    deci_data <= ad_data_in;
                end
            end else begin
                win_cnt <= win_cnt + RATE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dso_decimator.sv
// Scoreboard bench for dso_decimator: a window-list reference model queues
// expected strobes and restart pulses; a negedge monitor checks them.
module tb_dso_decimator;

    logic        ad_clk = 1'b0;
    logic        rst;
    logic [7:0]  ad_data_in;
    logic [23:0] deci_rate;
    logic        deci_mode;
    logic        deci_valid;
    logic [7:0]  deci_data;
    logic        cfg_restart;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         due;
        logic [7:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          rst_q[$];
    logic [7:0]  win[$];
    logic [23:0] cur_rate;
    logic        cur_mode;
    bit          ph;
    int          mon_now;
    bit          mon_exp_r;

    always #5 ad_clk = ~ad_clk;

    dso_decimator #(.RATE_W(24)) dut (
        .ad_clk      (ad_clk),
        .rst         (rst),
        .ad_data_in  (ad_data_in),
        .deci_rate   (deci_rate),
        .deci_mode   (deci_mode),
        .deci_valid  (deci_valid),
        .deci_data   (deci_data),
        .cfg_restart (cfg_restart)
    );

    function automatic int now_idx();
        return int'($time / 10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, now_idx());
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        rst_q.delete();
        win.delete();
        ph       = 1'b0;
        cur_rate = deci_rate;
        cur_mode = deci_mode;
    endtask

    // Reference: collect the window's samples, decide the output when the
    // window holds Neff of them; any port config change discards the window.
    task automatic model_cycle(input int idx, input logic [7:0] d);
        int         neff;
        logic [7:0] mx;
        logic [7:0] mn;
        logic [7:0] val;
        if (deci_rate != cur_rate || deci_mode != cur_mode) begin
            cur_rate = deci_rate;
            cur_mode = deci_mode;
            win.delete();
            ph = 1'b0;
            rst_q.push_back(idx + 1);
        end else begin
            win.push_back(d);
            neff = (cur_rate == 0) ? 1 : int'(cur_rate);
            if (win.size() == neff) begin
                if (cur_mode) begin
                    mx = win[0];
                    mn = win[0];
                    foreach (win[i]) begin
                        if (win[i] > mx) mx = win[i];
                        if (win[i] < mn) mn = win[i];
                    end
                    val = ph ? mn : mx;
                    ph  = !ph;
                end else begin
                    val = win[win.size() - 1];
                end
                exp_q.push_back('{due: idx + 1, val: val});
                win.delete();
            end
        end
    endtask

    task automatic step(input logic [7:0] d);
        ad_data_in = d;
        model_cycle(now_idx(), d);
        @(negedge ad_clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        exp_q.delete();
        rst_q.delete();
        win.delete();
        #1;
        check("async_rst_valid", deci_valid, 0);
        check("async_rst_data", deci_data, 0);
        check("async_rst_restart", cfg_restart, 0);
        repeat (4) @(negedge ad_clk);
        rst = 1'b0;
        model_reset();
    endtask

    always @(negedge ad_clk) begin
        if (!rst) begin
            mon_now = now_idx();
            while (exp_q.size() > 0 && exp_q[0].due < mon_now) begin
                n_checks++;
                n_errors++;
                $display("FAIL missed_strobe: due cycle %0d, still absent at cycle %0d", exp_q[0].due, mon_now);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == mon_now) begin
                check("strobe_valid", deci_valid, 1);
                check("strobe_data", deci_data, exp_q[0].val);
                void'(exp_q.pop_front());
            end else begin
                check("idle_valid", deci_valid, 0);
            end
            while (rst_q.size() > 0 && rst_q[0] < mon_now) void'(rst_q.pop_front());
            mon_exp_r = (rst_q.size() > 0 && rst_q[0] == mon_now);
            if (mon_exp_r) void'(rst_q.pop_front());
            check("cfg_restart", cfg_restart, mon_exp_r);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rates[7] = '{0, 1, 2, 3, 5, 8, 13};
        rst        = 1'b1;
        deci_rate  = 24'd1;
        deci_mode  = 1'b0;
        ad_data_in = 8'h00;
        repeat (3) @(negedge ad_clk);
        check("reset_valid", deci_valid, 0);
        check("reset_data", deci_data, 0);
        check("reset_restart", cfg_restart, 0);
        rst = 1'b0;
        model_reset();

        // N=1 sample ramp
        for (int i = 0; i < 256; i++) step(8'(i));

        // N=4 sample ramp: 3, 7, 11, ...
        deci_rate = 24'd4;
        step(8'hAA);
        for (int i = 0; i < 40; i++) step(8'(i));

        // N=8 peak: spike in window 0, dip in window 1
        deci_rate = 24'd8;
        deci_mode = 1'b1;
        step(8'h80);
        for (int i = 0; i < 32; i++)
            step((i == 3) ? 8'hF0 : (i == 13) ? 8'h05 : 8'h80);

        // N 16 -> 5 after 7 cycles into a window
        deci_rate = 24'd16;
        deci_mode = 1'b0;
        step(8'h11);
        for (int i = 0; i < 23; i++) step(8'($urandom_range(255)));
        deci_rate = 24'd5;
        for (int i = 0; i < 20; i++) step(8'($urandom_range(255)));

        // SAMPLE -> PEAK exactly on a window-close cycle
        deci_rate = 24'd4;
        step(8'h22);
        for (int i = 0; i < 11; i++) step(8'($urandom_range(255)));
        deci_mode = 1'b1;
        for (int i = 0; i < 16; i++) step(8'($urandom_range(255)));

        // N=100, reset mid-window, then a full window after release
        deci_rate = 24'd100;
        deci_mode = 1'b0;
        step(8'h33);
        for (int i = 0; i < 130; i++) step(8'($urandom_range(1, 255)));
        do_reset();
        for (int i = 0; i < 210; i++) step(8'($urandom_range(255)));

        // Random configuration and data
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) begin
                deci_rate = 24'(rates[$urandom_range(6)]);
                deci_mode = 1'($urandom_range(1));
            end
            step(8'($urandom_range(255)));
        end

        #3;
        check("strobes_drained", exp_q.size(), 0);
        check("restarts_drained", rst_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
